// File: rtl/vdp99_pkg.sv
// Shared definitions for the VDP graphics-1 scanline fetch block:
// FSM state encoding and the display geometry constants.
package vdp99_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_NAME_RQ,
      ST_NAME_WT,
      ST_PAT_RQ,
      ST_PAT_WT,
      ST_COL_RQ,
      ST_COL_WT,
      ST_WRITE,
      ST_DONE
   } g1_state_e;

   // Visible scanlines per frame and 8-pixel tiles per scanline.
   localparam int ACTIVE_LINES   = 192;
   localparam int TILES_PER_LINE = 32;

   // True in the single-cycle states that issue a VRAM read.
   function automatic logic is_req_state(input g1_state_e s);
      return (s == ST_NAME_RQ) || (s == ST_PAT_RQ) || (s == ST_COL_RQ);
   endfunction

endpackage

// File: rtl/vdp_g1_fetch.sv
// Graphics-1 scanline fetch: for each of the 32 tile columns of a line,
// reads the name byte, then the pattern byte and the color byte it selects,
// and writes the pair into the line buffer.
module vdp_g1_fetch
   import vdp99_pkg::*;
#(
   parameter int VRAM_ADDR_WIDTH = 13,
   parameter int RD_LATENCY      = 1     // legal range 1..3
) (
   input  logic                       clk,
   input  logic                       reset,       // synchronous, active low
   input  logic                       start,
   input  logic [7:0]                 row,
   input  logic [3:0]                 name_base,
   input  logic [7:0]                 color_base,
   input  logic [2:0]                 pat_base,
   output logic [VRAM_ADDR_WIDTH-1:0] dma_addr,
   output logic                       dma_rd_tick,
   input  logic [7:0]                 vram_dout,
   output logic                       lb_wr,
   output logic [4:0]                 lb_addr,
   output logic [7:0]                 lb_pattern,
   output logic [7:0]                 lb_color,
   output logic                       busy,
   output logic                       done
);

   // Wait counter preload: the WT state exits when the counter reaches zero,
   // so it spends exactly RD_LATENCY cycles there.
   localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);
   localparam logic [4:0] LAST_COL  = 5'(TILES_PER_LINE - 1);
   localparam logic [7:0] LAST_ROW  = 8'(ACTIVE_LINES - 1);

   g1_state_e   state_q, state_d;
   logic [4:0]  col_q, col_d;
   logic [1:0]  wait_q, wait_d;
   logic [7:0]  row_q, row_d;
   logic [3:0]  nbase_q, nbase_d;
   logic [7:0]  cbase_q, cbase_d;
   logic [2:0]  pbase_q, pbase_d;
   logic [7:0]  name_q, name_d;
   logic [7:0]  pat_q, pat_d;
   logic [7:0]  color_q, color_d;
   logic [13:0] addr14;

   // VRAM address for the request issued this cycle (zero outside requests).
   always_comb begin
      addr14 = '0;
      case (state_q)
         ST_NAME_RQ: addr14 = {nbase_q, row_q[7:3], col_q};
         ST_PAT_RQ:  addr14 = {pbase_q, name_q, row_q[2:0]};
         ST_COL_RQ:  addr14 = {cbase_q, 1'b0, name_q[7:3]};
         default:    addr14 = '0;
      endcase
   end

   // Next-state logic: sequence the three reads per tile, then the write.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      wait_d  = wait_q;
      row_d   = row_q;
      nbase_d = nbase_q;
      cbase_d = cbase_q;
      pbase_d = pbase_q;
      name_d  = name_q;
      pat_d   = pat_q;
      color_d = color_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Line parameters are frozen here for the whole line.
               row_d   = row;
               nbase_d = name_base;
               cbase_d = color_base;
               pbase_d = pat_base;
               col_d   = '0;
               state_d = (row > LAST_ROW) ? ST_DONE : ST_NAME_RQ;
            end
         end
         ST_NAME_RQ: begin
            wait_d  = WAIT_LAST;
            state_d = ST_NAME_WT;
         end
         ST_NAME_WT: begin
            if (wait_q == 2'd0) begin
               name_d  = vram_dout;
               state_d = ST_PAT_RQ;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         ST_PAT_RQ: begin
            wait_d  = WAIT_LAST;
            state_d = ST_PAT_WT;
         end
         ST_PAT_WT: begin
            if (wait_q == 2'd0) begin
               pat_d   = vram_dout;
               state_d = ST_COL_RQ;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         ST_COL_RQ: begin
            wait_d  = WAIT_LAST;
            state_d = ST_COL_WT;
         end
         ST_COL_WT: begin
            if (wait_q == 2'd0) begin
               color_d = vram_dout;
               state_d = ST_WRITE;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         ST_WRITE: begin
            if (col_q == LAST_COL) begin
               col_d   = '0;
               state_d = ST_DONE;
            end else begin
               col_d   = col_q + 5'd1;
               state_d = ST_NAME_RQ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any line in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         wait_q  <= '0;
         row_q   <= '0;
         nbase_q <= '0;
         cbase_q <= '0;
         pbase_q <= '0;
         name_q  <= '0;
         pat_q   <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         wait_q  <= wait_d;
         row_q   <= row_d;
         nbase_q <= nbase_d;
         cbase_q <= cbase_d;
         pbase_q <= pbase_d;
         name_q  <= name_d;
         pat_q   <= pat_d;
         color_q <= color_d;
      end
   end

   assign dma_addr    = VRAM_ADDR_WIDTH'(addr14);
   assign dma_rd_tick = is_req_state(state_q);
   assign lb_wr       = (state_q == ST_WRITE);
   assign lb_addr     = col_q;
   assign lb_pattern  = pat_q;
   assign lb_color    = color_q;
   assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done        = (state_q == ST_DONE);

endmodule
